// File: rtl/uio_uart_pkg.sv
// uio_uart_pkg: shared state encoding and frame constants for the uio UART transmitter.
package uio_uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
  localparam int UART_DATA_BITS = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/uio_sync_fifo.sv
// uio_sync_fifo: first-word fall-through synchronous FIFO with wrap-bit pointers.
module uio_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0] r_wptr, r_rptr;
  logic w_push, w_pop;
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= din;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end
  assign dout  = r_mem[r_rptr[AW-1:0]];
  assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign empty = r_wptr == r_rptr;
  assign count = r_wptr - r_rptr;
endmodule

// File: rtl/uio_uart_tx.sv
// uio_uart_tx: buffered 8N1 UART transmitter driving uio_out[0]/uio_oe[0].
module uio_uart_tx
  import uio_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [7:0]                        wr_data,
  input  logic                              wr_valid,
  output logic                              wr_ready,
  output logic                              tx,
  output logic                              tx_oe,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);
  uart_state_t r_state, w_state_n;
  logic [15:0] r_baud, w_baud_n;
  logic [2:0]  r_bit, w_bit_n;
  logic [7:0]  r_shift, w_shift_n, w_head;
  logic        r_tx, w_tx_n, r_oe, w_pop, w_full, w_empty, w_bit_end;

  uio_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_valid),
    .pop   (w_pop),
    .din   (wr_data),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (fifo_count)
  );

  assign w_bit_end = r_baud == 16'(CLKS_PER_BIT - 1);

  always_comb begin
    w_state_n = r_state;
    w_baud_n  = w_bit_end ? '0 : r_baud + 1'b1;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_pop     = 1'b0;
    case (r_state)
      IDLE: begin
        w_baud_n = '0;
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_shift_n = w_head;
          w_bit_n   = '0;
          w_state_n = START;
        end
      end
      START: if (w_bit_end) w_state_n = DATA;
      DATA: if (w_bit_end) begin
        w_shift_n = r_shift >> 1;
        w_bit_n   = r_bit + 1'b1;
        if (r_bit == 3'(UART_DATA_BITS - 1)) w_state_n = STOP;
      end
      STOP: if (w_bit_end) begin
        // pop at the last stop cycle so the next start bit follows with no gap
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_shift_n = w_head;
          w_bit_n   = '0;
          w_state_n = START;
        end else begin
          w_state_n = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase
    w_tx_n = (w_state_n == START) ? 1'b0 : (w_state_n == DATA) ? w_shift_n[0] : UART_IDLE_LEVEL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= UART_IDLE_LEVEL;
      r_oe    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_baud  <= w_baud_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
      r_tx    <= w_tx_n;
      r_oe    <= 1'b1;
    end
  end

  assign tx       = r_tx;
  assign tx_oe    = r_oe;
  assign wr_ready = !w_full;
  assign busy     = (r_state != IDLE) || !w_empty;
endmodule

// File: doc/uio_uart_tx.md
Name: uio_uart_tx

Overview:
- Transmit-direction companion to the byte-input path on the dedicated pins.
- Accepts parallel bytes through a valid/ready write port and buffers them in a small FIFO.
- Serialises each byte as UART 8N1 on one bidirectional IO pin (uio_out[0]), driving the matching output enable.
- Sits between the top-level pin logic and the uio_out/uio_oe assignments.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per UART bit; legal range 2..65535.
- FIFO_DEPTH, 4, byte slots in the input FIFO; must be a power of two, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- wr_data  in  8  byte to transmit.
- wr_valid  in  1  wr_data is valid this cycle.
- wr_ready  out  1  FIFO can accept a byte; equals !full.
- tx  out  1  serial line, to uio_out[0].
- tx_oe  out  1  output enable, to uio_oe[0].
- busy  out  1  high while a frame is in progress or the FIFO is non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  bytes currently buffered, excluding the frame in flight.

Behaviour:
- Clock and reset:
  - Single clock domain: clk.
  - rst is synchronous, active-high; it is sampled only on the rising edge of clk.
- Reset values: tx=1, tx_oe=0, busy=0, fifo_count=0, wr_ready=1, FSM=IDLE, FIFO pointers=0.
- tx_oe goes to 1 on the first edge with rst low and stays 1 until the next reset.
- Reset mid-frame aborts the frame. tx returns high on that edge and all FIFO contents are discarded.
- Write handshake:
  - A push occurs on a rising edge when wr_valid && wr_ready.
  - wr_ready is purely !full. A pop in the same cycle does not make room for a push while full.
  - wr_valid while full is ignored; no data is corrupted.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. When the FIFO is non-empty, pop the head into the shift register, set the bit counter to 0 and the baud counter to 0, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx = shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles. After each bit, shift right and increment the bit counter. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - If the FIFO is non-empty at the last STOP cycle, pop directly and go to START (back-to-back frames, no idle gap).
    - Otherwise go to IDLE.
- Latency: a byte pushed into an empty FIFO with FSM=IDLE at edge N is popped at edge N+1. tx falls after edge N+1.
- Frame length: exactly 10*CLKS_PER_BIT cycles.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps. A bit boundary occurs when the count equals CLKS_PER_BIT-1.
- FIFO:
  - Pointers are log2(FIFO_DEPTH)+1 bits wide.
  - full when the pointer MSBs differ and the rest are equal; empty when the pointers are equal.
  - Pointer wrap-around is natural binary overflow.
  - Simultaneous push and pop when neither full nor empty leaves fifo_count unchanged.
  - Simultaneous push and pop when empty: the push lands and the pop does not occur (pop requires !empty before the edge).
- busy = (FSM != IDLE) || !empty. It is registered-equivalent: no combinational path from wr_valid.
- tx is driven directly from a register, glitch-free.

Decomposition:
- Package uio_uart_pkg:
  - State enum: IDLE, START, DATA, STOP.
  - Constants: UART_DATA_BITS=8, UART_IDLE_LEVEL=1'b1.
- Sub-module uio_sync_fifo:
  - Parameters: WIDTH, DEPTH.
  - Ports: clk, rst, push, pop, din, dout, full, empty, count.
  - dout is the head entry, readable combinationally (first-word fall-through).
- The FSM, baud counter and shifter stay in uio_uart_tx.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
1. Reset → after rst deasserts: tx=1, tx_oe=1 from the first non-reset edge; busy=0, fifo_count=0, wr_ready=1.
2. Push 0xA5 once while idle → tx falls after the next edge. Line samples every 4 cycles read: 0, 1,0,1,0,0,1,0,1, 1. busy falls 40 cycles after tx fell.
3. Push 0x01, 0x02, 0x03, 0x04, 0x05 on consecutive cycles → the first four are accepted (0x01 is popped at the next edge, freeing a slot). 0x05 is accepted only while wr_ready=1. Five frames go out back-to-back with no idle cycles between a STOP and the next START. Received order is 0x01..0x05.
4. Fill the FIFO while a frame is in flight (fifo_count=4, wr_ready=0), then hold wr_valid=1 with data 0xFF → the byte is not accepted until a pop. Received data never contains a spurious 0xFF.
5. Assert rst for one cycle in the middle of DATA of 0x3C with 2 bytes queued → tx=1 and fifo_count=0 after that edge. No further frames are sent. A new push of 0x81 transmits correctly.
6. Push 0x00 then 0xFF → the line shows 9 consecutive low bit-times, then the stop bit, start bit, 8 high bits and stop bit. Total frame boundaries land at cycles 40 and 80.
